// File: rtl/gpio_display_sequencer_if.sv
// rtl/gpio_display_sequencer_if.sv - frame, CPU and GPIO bus signals of the display sequencer
interface gpio_display_sequencer_if;
    logic         frame_valid;
    logic         frame_ready;
    logic [127:0] frame_screen;
    logic [3:0]   frame_sevseg;
    logic         cpu_write;
    logic [63:0]  cpu_address;
    logic [63:0]  cpu_data;
    logic         cpu_stall;
    logic         gpio_write;
    logic         gpio_read;
    logic [63:0]  gpio_address;
    logic [63:0]  gpio_data;
    logic         busy;

    modport master (
        output frame_valid, frame_screen, frame_sevseg, cpu_write, cpu_address, cpu_data,
        input  frame_ready, cpu_stall, gpio_write, gpio_read, gpio_address, gpio_data, busy
    );

    modport slave (
        input  frame_valid, frame_screen, frame_sevseg, cpu_write, cpu_address, cpu_data,
        output frame_ready, cpu_stall, gpio_write, gpio_read, gpio_address, gpio_data, busy
    );
endinterface

// File: rtl/gpio_display_sequencer.sv
// rtl/gpio_display_sequencer.sv - splits a display frame into three GPIO writes, arbitrated against CPU writes
module gpio_display_sequencer #(
    parameter logic [63:0] BASE_ADDR = 64'h0500_0000_0000_0000
) (
    input  logic                            clock,
    input  logic                            reset_n,
    gpio_display_sequencer_if.slave         bus
);
    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, WR_SEG} state_t;

    state_t         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [127:0]   screen_q, screen_d;
    logic [3:0]     sevseg_q, sevseg_d;
    logic           gpio_write_q, gpio_write_d;
    logic [63:0]    gpio_address_q, gpio_address_d;
    logic [63:0]    gpio_data_q, gpio_data_d;
    logic           busy;
    logic           cpu_win;
    logic           seq_win;

    assign busy    = (state_q != IDLE);
    // The CPU loses only once it has already taken two beats from a waiting frame.
    assign cpu_win = bus.cpu_write && (cnt_q != 2'd2);
    assign seq_win = busy && !cpu_win;

    assign bus.frame_ready  = (state_q == IDLE) && reset_n;
    assign bus.cpu_stall    = !reset_n || (bus.cpu_write && !cpu_win);
    assign bus.busy         = busy;
    assign bus.gpio_write   = gpio_write_q;
    assign bus.gpio_read    = 1'b0;
    assign bus.gpio_address = gpio_address_q;
    assign bus.gpio_data    = gpio_data_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        screen_d       = screen_q;
        sevseg_d       = sevseg_q;
        gpio_write_d   = 1'b0;
        gpio_address_d = gpio_address_q;
        gpio_data_d    = gpio_data_q;

        if (cpu_win) begin
            gpio_write_d   = 1'b1;
            gpio_address_d = bus.cpu_address;
            gpio_data_d    = bus.cpu_data;
            if (busy) begin
                cnt_d = cnt_q + 2'd1;
            end
        end else if (seq_win) begin
            gpio_write_d = 1'b1;
            cnt_d        = 2'd0;
            case (state_q)
                WR_LO: begin
                    gpio_address_d = BASE_ADDR;
                    gpio_data_d    = screen_q[63:0];
                    state_d        = WR_HI;
                end
                WR_HI: begin
                    gpio_address_d = BASE_ADDR + 64'd1;
                    gpio_data_d    = screen_q[127:64];
                    state_d        = WR_SEG;
                end
                WR_SEG: begin
                    gpio_address_d = BASE_ADDR + 64'd2;
                    gpio_data_d    = {60'b0, sevseg_q};
                    state_d        = IDLE;
                end
                default: begin
                    gpio_write_d = 1'b0;
                end
            endcase
        end

        // Acceptance runs alongside a CPU beat; the frame's first arbitration is next cycle.
        if (state_q == IDLE) begin
            cnt_d = 2'd0;
            if (bus.frame_valid) begin
                screen_d = bus.frame_screen;
                sevseg_d = bus.frame_sevseg;
                state_d  = WR_LO;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= 2'd0;
            screen_q       <= '0;
            sevseg_q       <= '0;
            gpio_write_q   <= 1'b0;
            gpio_address_q <= '0;
            gpio_data_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            screen_q       <= screen_d;
            sevseg_q       <= sevseg_d;
            gpio_write_q   <= gpio_write_d;
            gpio_address_q <= gpio_address_d;
            gpio_data_q    <= gpio_data_d;
        end
    end
endmodule

// File: doc/gpio_display_sequencer.md
# gpio_display_sequencer

Sequencer and arbiter in front of the GPIO display peripheral's write port. It accepts a whole display frame (128-bit screen image plus 4-bit seven-segment value) through a valid/ready handshake and breaks it into three ordered register writes. It shares the single GPIO bus with direct CPU memory-mapped writes. CPU writes have priority, with a bounded-starvation rule so a frame always completes.

## Interface
- BASE_ADDR, 64'h0500_0000_0000_0000, GPIO register base; screen-low at +0, screen-high at +1, seven-seg at +2
- clock  in  1  single clock; all state updates on posedge
- reset_n  in  1  synchronous, active-low reset
- frame_valid  in  1  frame offered
- frame_ready  out  1  sequencer can accept a frame this cycle
- frame_screen  in  128  screen image; [63:0] low word, [127:64] high word
- frame_sevseg  in  4  seven-segment digit
- cpu_write  in  1  CPU write request to the GPIO bus
- cpu_address  in  64  CPU write address
- cpu_data  in  64  CPU write data
- cpu_stall  out  1  CPU request not granted this cycle; the CPU holds its request stable
- gpio_write  out  1  registered write strobe to the GPIO peripheral
- gpio_read  out  1  tied 0
- gpio_address  out  64  registered bus address
- gpio_data  out  64  registered bus data
- busy  out  1  frame in progress (state != IDLE)

## Operation
- FSM states: IDLE, WR_LO, WR_HI, WR_SEG.
- frame_ready = (state == IDLE) && reset_n.
- On frame_valid && frame_ready:
  - frame_screen and frame_sevseg are captured into internal registers.
  - IDLE -> WR_LO.
- Each cycle the arbiter decides one bus beat.
- The CPU wins when cpu_write=1 and the starvation counter cnt != 2:
  - cpu_stall=0; the bus loads cpu_address/cpu_data with gpio_write=1.
  - If busy, the FSM holds its state and cnt increments.
- The sequencer wins when busy && (cpu_write==0 || cnt==2):
  - The bus loads the beat for the current state.
  - The FSM advances WR_LO->WR_HI->WR_SEG->IDLE.
  - cnt clears to 0.
  - cpu_stall = cpu_write.
- Sequencer beats:
  - WR_LO: address BASE_ADDR, data screen[63:0]
  - WR_HI: address BASE_ADDR+1, data screen[127:64]
  - WR_SEG: address BASE_ADDR+2, data {60'b0, sevseg}
- No winner (IDLE, no cpu_write): gpio_write loads 0. gpio_address and gpio_data hold their values.
- cnt is 2 bits, saturates at 2, and clears when state is IDLE.
- A frame accepted at edge E0 uses the captured copy; later frame_screen changes have no effect.
- CPU writes to BASE_ADDR..+2 during a frame pass through unchanged. Ordering on the bus is exactly the grant order; there is no merging.

## Timing
- Reset (reset_n=0 at a posedge) loads:
  - state IDLE, cnt 0
  - gpio_write 0, gpio_read 0, gpio_address 0, gpio_data 0
  - busy 0
  - captured frame 0
- While reset_n=0: frame_ready=0 and cpu_stall=1 (combinational).
- Reset mid-frame abandons the frame. No further beats are issued; beats already on the bus are not retracted.
- Grant decision and cpu_stall are combinational in cycle N. The granted beat is visible on gpio_* after the posedge ending cycle N, and is held for one full cycle so the peripheral's negedge capture sees stable data.
- Uncontended frame, accepted at E0: beats visible after E1 (lo), E2 (hi), E3 (seg). busy is high from E0 to E3. The next frame can be accepted at E4 at the earliest, giving 1 frame per 4 cycles.
- Worst-case frame under continuous cpu_write: each sequencer beat waits at most 2 CPU beats, so the frame completes within 9 cycles of acceptance.
- A CPU request in IDLE is never stalled: 1-cycle latency to the bus.
- Simultaneous frame_valid and cpu_write in IDLE:
  - Both are accepted.
  - The CPU beat goes out after E0.
  - The frame's WR_LO arbitration starts in the next cycle.

## Test plan
- Reset, then frame screen=128'h1111..._2222..., sevseg=4'hA, no CPU traffic -> gpio_write=1 on 3 consecutive cycles with (0x0500..00, 64'h2222...), (0x0500..01, 64'h1111...), (0x0500..02, 64'hA); frame_ready returns high 4 cycles after acceptance.
- IDLE, cpu_write with address 0x1234 and data 0xBEEF -> cpu_stall=0; next cycle gpio_address=0x1234, gpio_data=0xBEEF, gpio_write=1.
- Frame accepted while cpu_write is held high continuously -> bus order CPU,CPU,LO,CPU,CPU,HI,CPU,CPU,SEG; cpu_stall=1 exactly on the LO/HI/SEG decision cycles; busy drops after SEG.
- frame_valid and cpu_write together in IDLE -> CPU beat first, then LO/HI/SEG; no beat lost.
- Assert reset_n=0 after the LO beat -> no HI/SEG beats; all outputs at reset values; a new frame after release starts again at LO.
- Change frame_screen the cycle after acceptance -> emitted beats carry the originally captured values.
